// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
//
// Contents:
//   MD_MULT_CYCLES / MD_DIV_CYCLES - cycles the multiply/divide unit stays busy
//   TUSE_NONE                      - tuse code meaning "operand not read"
//   md_state_t                     - multiply/divide tracker state encoding
package hazard_ctrl_pkg;

    localparam logic [3:0] MD_MULT_CYCLES = 4'd5;
    localparam logic [3:0] MD_DIV_CYCLES  = 4'd10;
    localparam logic [1:0] TUSE_NONE      = 2'd3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// md_busy_tracker: tracks how long the multiply/divide unit is occupied.
// A start request in IDLE loads a down-counter with the operation latency;
// the unit reports busy for exactly that many cycles after the start cycle.
// Start requests arriving while busy are ignored.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (abandons any operation)
//   md_start in   mult/div issuing this cycle
//   md_div   in   1 = divide, 0 = multiply
//   md_busy  out  unit busy (state BUSY)
module md_busy_tracker
    import hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    md_state_t  state_reg, state_next;
    logic [3:0] md_cnt_reg, md_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= MD_IDLE;
            md_cnt_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            md_cnt_reg <= md_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        md_cnt_next = md_cnt_reg;
        md_busy     = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                if (md_start) begin
                    state_next  = MD_BUSY;
                    md_cnt_next = md_div ? MD_DIV_CYCLES : MD_MULT_CYCLES;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                // Last busy cycle when the counter reaches 1; md_start is
                // deliberately not looked at here.
                if (md_cnt_reg == 4'd1) begin
                    state_next  = MD_IDLE;
                    md_cnt_next = 4'd0;
                end else begin
                    md_cnt_next = md_cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next  = MD_IDLE;
                md_cnt_next = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall generation for a 5-stage pipeline with a multi-cycle
// multiply/divide unit. Stall is purely combinational: a data hazard exists
// when a D-stage source is produced by E or M later than D needs it
// (tnew > tuse); an MD hazard exists when D touches HI/LO while the MD unit
// is busy or starting. A stall freezes PC and IF/ID and bubbles ID/EX.
//
// Optional feature: define HAZARD_STALL_CNT_EN to add the 32-bit stall_cnt
// output counting stalled cycles.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   d_rs, d_rt                 D-stage source registers
//   d_tuse_rs, d_tuse_rt       cycles until operand is used (3 = unused)
//   d_md_use                   D instruction uses HI/LO
//   e_wr, m_wr                 destination registers in E / M
//   e_regwrite, m_regwrite     write enables in E / M
//   e_tnew, m_tnew             cycles until E / M result is ready
//   e_md_start, e_md_div       mult/div issue in E, 1 = div
//   f_en, d_en, e_clr          PC enable, IF/ID enable, ID/EX bubble
//   md_busy                    multiply/divide unit busy
//   stall_cnt                  cumulative stall cycles (HAZARD_STALL_CNT_EN)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_md_use,
    input  logic [4:0]  e_wr,
    input  logic [4:0]  m_wr,
    input  logic        e_regwrite,
    input  logic        m_regwrite,
    input  logic [2:0]  e_tnew,
    input  logic [2:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        f_en,
    output logic        d_en,
    output logic        e_clr,
    output logic        md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic [1:0][4:0] src;
    logic [1:0][1:0] tuse;
    logic [1:0]      src_hazard;
    logic            data_stall;
    logic            md_stall;
    logic            stall;

    assign src[0]  = d_rs;
    assign src[1]  = d_rt;
    assign tuse[0] = d_tuse_rs;
    assign tuse[1] = d_tuse_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // Register 0 is never a real dependency; tuse = 3 means the
            // operand is not read (needed explicitly since tnew can exceed 3).
            assign src_hazard[gi] = (src[gi] != 5'd0) && (tuse[gi] != TUSE_NONE) &&
                ((e_regwrite && (e_wr == src[gi]) && (e_tnew > {1'b0, tuse[gi]})) ||
                 (m_regwrite && (m_wr == src[gi]) && (m_tnew > {1'b0, tuse[gi]})));
        end
    endgenerate

    md_busy_tracker u_md_busy_tracker (
        .clk      (clk),
        .reset    (reset),
        .md_start (e_md_start),
        .md_div   (e_md_div),
        .md_busy  (md_busy)
    );

    assign data_stall = |src_hazard;
    assign md_stall   = d_md_use && (md_busy || e_md_start);
    assign stall      = data_stall || md_stall;

    // While reset is high the pipeline is allowed to flow regardless of inputs.
    assign f_en  = reset || !stall;
    assign d_en  = reset || !stall;
    assign e_clr = !reset && stall;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= 32'd0;
        end else if (stall) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Each cycle the stimulus drives inputs
// just after the rising edge and pushes the hand-computed expected outputs
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wr, m_wr;
    logic [1:0]  d_tuse_rs, d_tuse_rt;
    logic        d_md_use, e_regwrite, m_regwrite, e_md_start, e_md_div;
    logic [2:0]  e_tnew, m_tnew;
    logic        f_en, d_en, e_clr, md_busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        string       name;
        logic        f_en;
        logic        d_en;
        logic        e_clr;
        logic        md_busy;
        bit          chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_md_use   (d_md_use),
        .e_wr       (e_wr),
        .m_wr       (m_wr),
        .e_regwrite (e_regwrite),
        .m_regwrite (m_regwrite),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .f_en       (f_en),
        .d_en       (d_en),
        .e_clr      (e_clr),
        .md_busy    (md_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (f_en !== e.f_en || d_en !== e.d_en || e_clr !== e.e_clr || md_busy !== e.md_busy) begin
                    n_fail++;
                    $display("FAIL %s: got f_en=%b d_en=%b e_clr=%b md_busy=%b, want f_en=%b d_en=%b e_clr=%b md_busy=%b",
                             e.name, f_en, d_en, e_clr, md_busy, e.f_en, e.d_en, e.e_clr, e.md_busy);
                end else begin
                    $display("ok   %s: f_en=%b d_en=%b e_clr=%b md_busy=%b",
                             e.name, f_en, d_en, e_clr, md_busy);
                end
`ifdef HAZARD_STALL_CNT_EN
                if (e.chk_cnt) begin
                    n_checks++;
                    if (stall_cnt !== e.cnt) begin
                        n_fail++;
                        $display("FAIL %s_cnt: got stall_cnt=%0d, want %0d", e.name, stall_cnt, e.cnt);
                    end else begin
                        $display("ok   %s_cnt: stall_cnt=%0d", e.name, stall_cnt);
                    end
                end
`endif
            end
        end
    end

    task automatic clr_in();
        d_rs = 5'd0; d_rt = 5'd0;
        d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_md_use = 1'b0;
        e_wr = 5'd0; m_wr = 5'd0;
        e_regwrite = 1'b0; m_regwrite = 1'b0;
        e_tnew = 3'd0; m_tnew = 3'd0;
        e_md_start = 1'b0; e_md_div = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stall = expected stall; d_en follows f_en by definition.
    task automatic expect_out(input string name, input logic stall_e, input logic busy_e);
        exp_t e;
        e.name = name; e.f_en = !stall_e; e.d_en = !stall_e; e.e_clr = stall_e;
        e.md_busy = busy_e; e.chk_cnt = 1'b0; e.cnt = 32'd0;
        sb.push_back(e);
    endtask

    task automatic expect_raw(input string name, input logic f_e, input logic c_e,
                              input logic busy_e, input bit chk, input logic [31:0] cnt_e);
        exp_t e;
        e.name = name; e.f_en = f_e; e.d_en = f_e; e.e_clr = c_e;
        e.md_busy = busy_e; e.chk_cnt = chk; e.cnt = cnt_e;
        sb.push_back(e);
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        // Reset held with a hazard on the inputs: outputs forced, unit idle.
        tick();
        d_rs = 5'd8; d_tuse_rs = 2'd0; e_wr = 5'd8; e_regwrite = 1'b1; e_tnew = 3'd2;
        expect_raw("reset_hold", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        reset = 1'b0; clr_in();
        expect_raw("idle_after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);

        // Data hazards
        tick(); clr_in();
        d_rs = 5'd8; d_tuse_rs = 2'd0; e_wr = 5'd8; e_regwrite = 1'b1; e_tnew = 3'd2;
        expect_out("e_rs_stall", 1'b1, 1'b0);
        tick(); clr_in();
        d_rt = 5'd9; d_tuse_rt = 2'd1; m_wr = 5'd9; m_regwrite = 1'b1; m_tnew = 3'd1;
        expect_out("m_rt_equal_nostall", 1'b0, 1'b0);
        tick(); clr_in();
        d_rt = 5'd9; d_tuse_rt = 2'd1; m_wr = 5'd9; m_regwrite = 1'b1; m_tnew = 3'd2;
        expect_out("m_rt_stall", 1'b1, 1'b0);
        tick(); clr_in();
        d_rs = 5'd0; d_tuse_rs = 2'd0; e_wr = 5'd0; e_regwrite = 1'b1; e_tnew = 3'd2;
        expect_out("reg0_nostall", 1'b0, 1'b0);
        tick(); clr_in();
        d_rs = 5'd5; d_tuse_rs = 2'd3; e_wr = 5'd5; e_regwrite = 1'b1; e_tnew = 3'd7;
        expect_out("tuse_none_nostall", 1'b0, 1'b0);
        tick(); clr_in();
        d_rs = 5'd5; d_tuse_rs = 2'd0; e_wr = 5'd5; e_regwrite = 1'b0; e_tnew = 3'd2;
        expect_out("no_regwrite_nostall", 1'b0, 1'b0);
        tick(); clr_in();
        d_rs = 5'd5; d_tuse_rs = 2'd0; e_wr = 5'd6; e_regwrite = 1'b1; e_tnew = 3'd2;
        expect_out("reg_mismatch_nostall", 1'b0, 1'b0);
        tick(); clr_in();
        d_rt = 5'd12; d_tuse_rt = 2'd2; e_wr = 5'd12; e_regwrite = 1'b1; e_tnew = 3'd3;
        expect_out("e_rt_tuse2_stall", 1'b1, 1'b0);

        // Divide: busy cycles 1..10, d_md_use stalls cycles 0..10
        tick(); clr_in();
        e_md_start = 1'b1; e_md_div = 1'b1; d_md_use = 1'b1;
        expect_out("div_c0", 1'b1, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            tick(); clr_in();
            d_md_use = 1'b1;
            if (c <= 10) expect_out($sformatf("div_c%0d", c), 1'b1, 1'b1);
            else         expect_out($sformatf("div_c%0d", c), 1'b0, 1'b0);
        end

        // Multiply with a second start at cycle 3: busy stays cycles 1..5
        tick(); clr_in();
        e_md_start = 1'b1;
        expect_out("mult_c0", 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            tick(); clr_in();
            if (c == 3) begin
                e_md_start = 1'b1; e_md_div = 1'b1;
            end
            if (c == 4) d_md_use = 1'b1;
            expect_out($sformatf("mult_c%0d", c), (c == 4), (c <= 5));
        end

        // Reset during a divide with md_cnt = 7 (cycle 4 after start)
        tick(); clr_in();
        e_md_start = 1'b1; e_md_div = 1'b1;
        expect_out("rst_div_c0", 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            tick(); clr_in();
            expect_out($sformatf("rst_div_c%0d", c), 1'b0, 1'b1);
        end
        tick(); clr_in();
        reset = 1'b1; d_md_use = 1'b1;
        expect_raw("rst_div_c4_inreset", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick(); clr_in();
            reset = 1'b0;
            d_rs = 5'd8; d_tuse_rs = 2'd0; e_wr = 5'd8; e_regwrite = 1'b1; e_tnew = 3'd2;
            expect_raw($sformatf("post_rst_stall%0d", c), 1'b0, 1'b1, 1'b0, 1'b1, 32'(c));
        end
        tick(); clr_in();
        expect_raw("post_rst_count3", 1'b1, 1'b0, 1'b0, 1'b1, 32'd3);

        // Drain scoreboard with a bounded wait.
        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
